// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift-register arbiter: FSM encoding,
// shift direction codes and the default register width.
package shift_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Shift direction as carried on reqN_dir
    localparam logic DIR_LEFT  = 1'b0;  // MSB leaves first
    localparam logic DIR_RIGHT = 1'b1;  // LSB leaves first

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/shift_reg_bidir.sv
// WIDTH-bit bidirectional shift register with parallel load and a
// registered serial output. Priority is load > left > right.
module shift_reg_bidir
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             left,
    input  logic             right,
    input  logic             shift_in,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic             shift_out
);

    logic [WIDTH-1:0] reg_q;
    logic             shift_out_q;

    // Register update; the bit that falls off the end is held in shift_out_q
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_q       <= '0;
            shift_out_q <= 1'b0;
        end else if (load) begin
            reg_q <= data;
        end else if (left) begin
            reg_q       <= {reg_q[WIDTH-2:0], shift_in};
            shift_out_q <= reg_q[WIDTH-1];
        end else if (right) begin
            reg_q       <= {shift_in, reg_q[WIDTH-1:1]};
            shift_out_q <= reg_q[0];
        end
    end

    assign q         = reg_q;
    assign shift_out = shift_out_q;

endmodule

// File: rtl/shift_arb_ctrl.sv
// Round-robin arbiter and sequencer that owns a shared bidirectional
// shift register: load a requester's word, shift it out serially, and
// return the reassembled stream plus the final register contents.
module shift_arb_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_dir,
    input  logic             req0_fill,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_dir,
    input  logic             req1_fill,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] rsp_reg,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_e           state_q;
    logic             id_q;
    logic             dir_q;
    logic             fill_q;
    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    cnt_q;
    logic             last_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic [WIDTH-1:0] rsp_reg_q;

    logic             grant_d;
    logic             accept_d;
    logic [CW-1:0]    cap_bit_d;
    logic [CW-1:0]    cap_pos_d;

    // Datapath controls, decoded from state so at most one is ever high
    logic             dp_load;
    logic             dp_left;
    logic             dp_right;
    logic [WIDTH-1:0] sr_q;
    logic             sr_out;

    // Round-robin grant: lone requester wins, ties go to the one not served last
    always_comb begin
        grant_d = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_d = ~last_q;
        end else if (req1_valid) begin
            grant_d = 1'b1;
        end
    end

    // Ready is suppressed while reset is held even though state reads IDLE
    assign req0_ready = reset && (state_q == ST_IDLE) && req0_valid && !grant_d;
    assign req1_ready = reset && (state_q == ST_IDLE) && req1_valid &&  grant_d;
    assign accept_d   = req0_ready || req1_ready;

    // Where the bit arriving from the datapath lands in the reassembled word;
    // bit k arrives one cycle after the shift that produced it
    always_comb begin
        cap_bit_d = (state_q == ST_DRAIN) ? LAST_IDX : (cnt_q - 1'b1);
        cap_pos_d = (dir_q == DIR_LEFT) ? (LAST_IDX - cap_bit_d) : cap_bit_d;
    end

    // Sequencer: accept, load, shift WIDTH times, drain the last bit, respond
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            id_q       <= 1'b0;
            dir_q      <= DIR_LEFT;
            fill_q     <= 1'b0;
            data_q     <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            rsp_data_q <= '0;
            rsp_reg_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        id_q    <= grant_d;
                        dir_q   <= grant_d ? req1_dir  : req0_dir;
                        fill_q  <= grant_d ? req1_fill : req0_fill;
                        data_q  <= grant_d ? req1_data : req0_data;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt_q   <= '0;
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cnt_q != '0) begin
                        rsp_data_q[cap_pos_d] <= sr_out;
                    end
                    if (cnt_q == LAST_IDX) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    rsp_data_q[cap_pos_d] <= sr_out;
                    rsp_reg_q             <= sr_q;
                    state_q               <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        last_q  <= id_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dp_load  = (state_q == ST_LOAD);
    assign dp_left  = (state_q == ST_SHIFT) && (dir_q == DIR_LEFT);
    assign dp_right = (state_q == ST_SHIFT) && (dir_q == DIR_RIGHT);

    shift_reg_bidir #(
        .WIDTH(WIDTH)
    ) u_sr (
        .clk      (clk),
        .reset    (reset),
        .load     (dp_load),
        .left     (dp_left),
        .right    (dp_right),
        .shift_in (fill_q),
        .data     (data_q),
        .q        (sr_q),
        .shift_out(sr_out)
    );

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_reg   = rsp_reg_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Directed bench for shift_arb_ctrl (WIDTH=4): single requesters, round-robin
// ties, response back-pressure, mid-shift reset, datapath control usage.
module tb_shift_arb_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_data, req1_data;
    logic       req0_dir, req1_dir;
    logic       req0_fill, req1_fill;
    logic       rsp_valid, rsp_ready;
    logic       rsp_id;
    logic [3:0] rsp_data, rsp_reg;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_load   = 0;
    int n_shift  = 0;
    int n_overlap = 0;
    int load_snap, shift_snap;

    always #5 clk = ~clk;

    shift_arb_ctrl #(.WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_data (req0_data),
        .req0_dir  (req0_dir),
        .req0_fill (req0_fill),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_data (req1_data),
        .req1_dir  (req1_dir),
        .req1_fill (req1_fill),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_reg   (rsp_reg),
        .busy      (busy)
    );

    always @(posedge clk) cyc++;

    // Observe the datapath controls once per cycle, mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            if (dut.dp_load) n_load++;
            if (dut.dp_left || dut.dp_right) n_shift++;
            if ((int'(dut.dp_load) + int'(dut.dp_left) + int'(dut.dp_right)) > 1) n_overlap++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge. Drives the request, waits for its grant,
    // and returns on the negedge after the accept edge with valid dropped.
    task automatic issue(input int src, input logic [3:0] d, input logic dir,
                         input logic fill, output int waited);
        int k;
        if (src == 0) begin
            req0_valid = 1'b1; req0_data = d; req0_dir = dir; req0_fill = fill;
        end else begin
            req1_valid = 1'b1; req1_data = d; req1_dir = dir; req1_fill = fill;
        end
        #2;
        k = 0;
        while (!((src == 0) ? req0_ready : req1_ready) && k < 30) begin
            @(negedge clk); #2;
            k++;
        end
        check("accept_in_time", 32'(k < 30), 32'd1);
        waited     = k;
        load_snap  = n_load;
        shift_snap = n_shift;
        @(posedge clk);
        @(negedge clk);
        if (src == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    // Called on the negedge after the accept edge; returns at the negedge+2
    // of the first RESP cycle.
    task automatic wait_rsp(input logic id_e, input logic [3:0] data_e,
                            input logic [3:0] reg_e, input string tag);
        int lat;
        lat = 0;
        #2;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk); #2;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd6);
        check({tag, "_id"},      32'(rsp_id),   32'(id_e));
        check({tag, "_data"},    32'(rsp_data), 32'(data_e));
        check({tag, "_reg"},     32'(rsp_reg),  32'(reg_e));
        check({tag, "_loads"},   32'(n_load - load_snap),   32'd1);
        check({tag, "_shifts"},  32'(n_shift - shift_snap), 32'd4);
        $display("txn %s: id=%0d data=%b reg=%b latency=%0d", tag, rsp_id, rsp_data, rsp_reg, lat);
    endtask

    initial begin
        int w;
        int prev_acc;
        logic got;
        reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        req0_dir = 1'b0; req1_dir = 1'b0;
        req0_fill = 1'b0; req1_fill = 1'b0;
        rsp_ready = 1'b1;

        // Reset state, with a request already pending
        @(negedge clk);
        req0_valid = 1'b1;
        #2;
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        check("rst_rsp_data",   32'(rsp_data),   32'd0);
        check("rst_rsp_reg",    32'(rsp_reg),    32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // req0 only: 1011 left fill 0
        issue(0, 4'b1011, 1'b0, 1'b0, w);
        wait_rsp(1'b0, 4'b1011, 4'b0000, "r0_left");
        @(negedge clk);

        // req1 only: 0110 right fill 1
        issue(1, 4'b0110, 1'b1, 1'b1, w);
        wait_rsp(1'b1, 4'b0110, 4'b1111, "r1_right");
        @(negedge clk);

        // Both valid from reset: alternate 0,1,0,1 every 8 cycles
        #2 reset = 1'b0;
        req0_valid = 1'b1; req0_data = 4'b1011; req0_dir = 1'b0; req0_fill = 1'b0;
        req1_valid = 1'b1; req1_data = 4'b0110; req1_dir = 1'b1; req1_fill = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            int k;
            #2;
            k = 0;
            while (!(req0_ready || req1_ready) && k < 30) begin
                @(negedge clk); #2;
                k++;
            end
            check("rr_accept_in_time", 32'(k < 30), 32'd1);
            got = req1_ready;
            check("rr_order", 32'(got), 32'(i % 2));
            if (i > 0) check("rr_spacing", 32'(cyc - prev_acc), 32'd8);
            prev_acc   = cyc;
            load_snap  = n_load;
            shift_snap = n_shift;
            @(posedge clk);
            @(negedge clk);
            if (i % 2 == 0) wait_rsp(1'b0, 4'b1011, 4'b0000, "rr_r0");
            else            wait_rsp(1'b1, 4'b0110, 4'b1111, "rr_r1");
            if (i == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            @(negedge clk);
        end

        // Back-pressure: rsp_ready low for 3 RESP cycles, requesters waiting
        rsp_ready = 1'b0;
        issue(1, 4'b1001, 1'b0, 1'b0, w);
        wait_rsp(1'b1, 4'b1001, 4'b0000, "bp_r1");
        req0_valid = 1'b1; req0_data = 4'b0101;
        req1_valid = 1'b1; req1_data = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin
                @(negedge clk); #2;
            end else begin
                #1;
            end
            check("bp_valid",  32'(rsp_valid),  32'd1);
            check("bp_id",     32'(rsp_id),     32'd1);
            check("bp_data",   32'(rsp_data),   32'b1001);
            check("bp_reg",    32'(rsp_reg),    32'b0000);
            check("bp_ready0", 32'(req0_ready), 32'd0);
            check("bp_ready1", 32'(req1_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready  = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #2;
        check("bp_valid_4th", 32'(rsp_valid), 32'd1);
        @(negedge clk); #2;
        check("bp_done_valid", 32'(rsp_valid), 32'd0);
        check("bp_done_busy",  32'(busy),      32'd0);

        // Reset during the 2nd SHIFT cycle aborts and clears everything
        @(negedge clk);
        issue(0, 4'b0011, 1'b1, 1'b0, w);
        @(negedge clk);
        @(negedge clk);
        #2;
        check("ab_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        req0_valid = 1'b1;
        #1;
        check("ab_busy",      32'(busy),       32'd0);
        check("ab_rsp_valid", 32'(rsp_valid),  32'd0);
        check("ab_rsp_id",    32'(rsp_id),     32'd0);
        check("ab_rsp_data",  32'(rsp_data),   32'd0);
        check("ab_rsp_reg",   32'(rsp_reg),    32'd0);
        check("ab_ready0",    32'(req0_ready), 32'd0);
        check("ab_sr_clear",  32'(dut.sr_q),   32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        issue(0, 4'b1100, 1'b0, 1'b1, w);
        check("ab_first_edge_accept", 32'(w), 32'd0);
        wait_rsp(1'b0, 4'b1100, 4'b1111, "ab_r0");
        @(negedge clk);

        check("ctl_overlap", 32'(n_overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_arb_ctrl.md
# shift_arb_ctrl

Controller that shares one WIDTH-bit bidirectional shift register between two requesters. Each request is a parallel word, a shift direction and a fill bit. The block arbitrates round-robin, loads the word, and shifts it out serially over WIDTH cycles. It returns the serial-out stream reassembled as a word, plus the register's final contents. It sits between command sources and the shift datapath and is the only agent that drives that datapath's load and shift controls.

## Interface
- `WIDTH`, default 4: shift register width, ≥2.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  request pending; held with its payload until accepted.
- `req0_ready` / `req1_ready`  out  1  request accepted on a cycle with valid & ready.
- `req0_data` / `req1_data`  in  WIDTH  word to load.
- `req0_dir` / `req1_dir`  in  1  0 = shift left (MSB out first), 1 = shift right (LSB out first).
- `req0_fill` / `req1_fill`  in  1  serial-in bit used on every shift.
- `rsp_valid`  out  1  response held until `rsp_ready`.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  1  index of the served requester.
- `rsp_data`  out  WIDTH  serial-out stream reassembled in original bit positions.
- `rsp_reg`  out  WIDTH  register contents after the last shift.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DRAIN, RESP.
- **IDLE.** The grant goes to the single valid requester. If both are valid, it goes to the one not served last. `reqN_ready` = IDLE & grant==N; it is combinational from state, grant and valids. On accept, latch id, dir, fill and data, then go to LOAD.
- **LOAD.** Assert load for one cycle (register ← data), clear the bit counter, then go to SHIFT.
- **SHIFT.** Assert exactly one of left/right for WIDTH cycles; load, left and right are never asserted together. The counter counts 0..WIDTH-1, and the last count goes to DRAIN.
- **Serial-out.** The datapath registers the shifted-out bit on the shift edge. The controller captures it on the following edge. Bit k (k = 0..WIDTH-1) is captured on SHIFT cycles 1..WIDTH-1 and in DRAIN.
- **Placement.** Left: bit k goes to `rsp_data[WIDTH-1-k]`. Right: bit k goes to `rsp_data[k]`. Therefore `rsp_data` always equals the loaded word.
- **DRAIN.** Capture the last bit, copy the register into `rsp_reg`, and go to RESP. `rsp_reg` equals {WIDTH{fill}}.
- **RESP.** `rsp_valid`=1 with id/data/reg stable. On `rsp_ready`, update the last-served pointer and go to IDLE.
- **No overlap.** There is no request accept in any non-IDLE state.
- **Reset.** All state clears asynchronously and the datapath register clears to 0. All outputs are 0 (`req*_ready` is 0 while reset is asserted). The last-served pointer resets to 1, so req0 wins the first tie.

## Timing
- Accept edge = E0. LOAD edge = E1. Shift edges = E2..E(WIDTH+1). Last capture = E(WIDTH+2).
- `rsp_valid` rises after E(WIDTH+2): WIDTH+2 cycles after accept (6 for WIDTH=4).
- Response handshake edge = Er. The earliest next accept is Er+1, so throughput is one request per WIDTH+4 cycles with `rsp_ready` tied high.
- A reset assertion mid-operation aborts immediately and drops the response. After release, the block is in IDLE and the first rising edge can accept a request.
- A requester deasserting valid before accept is legal; no grant is recorded for it.

## Structure
- Package `shift_ctrl_pkg`: FSM state encoding, `DIR_LEFT`/`DIR_RIGHT` constants, default `WIDTH`.
- Sub-module `shift_reg_bidir`: WIDTH-bit register with inputs load, left, right, shift_in and data, and a registered shift_out.
  - Priority is load > left > right.
  - Reset is asynchronous, active-low, and clears both the register and shift_out.
  - Its contents are exposed for `rsp_reg`.
- The controller instantiates it once.

## Test plan
- req0 only: data=1011, dir=left, fill=0 → accept, `rsp_valid` 6 cycles later, id=0, `rsp_data`=1011, `rsp_reg`=0000.
- req1 only: data=0110, dir=right, fill=1 → id=1, `rsp_data`=0110, `rsp_reg`=1111.
- Both valid continuously from reset, `rsp_ready`=1 → served order 0,1,0,1; each accept exactly 8 cycles after the previous one.
- `rsp_ready` low for 3 cycles in RESP → `rsp_valid`/id/data/reg stable, both `req*_ready` stay 0, and the handshake completes on the 4th cycle.
- Reset asserted during the 2nd SHIFT cycle → all outputs 0 immediately. After release, a req0 with 1100/left/1 returns `rsp_data`=1100 and `rsp_reg`=1111.
- Throughout every run → the datapath never sees more than one of load/left/right in a cycle, and sees exactly 1 load and WIDTH shifts per request.
